// File: rtl/ycbcr_pipe_ctrl.sv
// Flow controller for the ce-enabled YCbCr conversion pipeline: valid tracking, back-pressure, flush.
// Define YCBCR_PIPE_CTRL_SKID_EN to add a registered 2-entry output buffer that decouples m_ready from ce.
module ycbcr_pipe_ctrl #(
  parameter int unsigned LATENCY = 8,
  parameter int unsigned N       = 24
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         s_valid,
  output logic         s_ready,
  output logic         ce,
  input  logic [N-1:0] pipe_data,
  output logic         m_valid,
  output logic [N-1:0] m_data,
  input  logic         m_ready,
  input  logic         flush,
  output logic         flush_done,
  output logic         busy
);

  localparam int unsigned CW = $clog2(LATENCY + 3);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  state_t             state, state_nxt;
  logic [LATENCY-1:0] vld;
  logic [CW-1:0]      cnt, cnt_nxt;
  logic               flush_done_nxt;
  logic               src_acc, snk_acc;

  assign s_ready = ce && (state != FLUSH);
  assign src_acc = s_valid && s_ready;
  assign snk_acc = m_valid && m_ready;
  assign busy    = (cnt != '0);

  // Valid flags travel alongside the datapath and freeze with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= '0;
    end else if (ce) begin
      vld[0] <= src_acc;
      for (int k = 1; k < int'(LATENCY); k++) begin
        vld[k] <= vld[k-1];
      end
    end
  end

`ifdef YCBCR_PIPE_CTRL_SKID_EN
  logic         out_valid, skid_valid;
  logic [N-1:0] out_data, skid_data;
  logic         ingress;

  // ce depends only on the skid flag, so no combinational m_ready path reaches the pipe.
  assign ce      = !skid_valid;
  assign ingress = ce && vld[LATENCY-1];
  assign m_valid = out_valid;
  assign m_data  = out_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
    end else if (!out_valid || m_ready) begin
      if (skid_valid) begin
        out_valid  <= 1'b1;
        out_data   <= skid_data;
        skid_valid <= 1'b0;
      end else begin
        out_valid <= ingress;
        if (ingress) begin
          out_data <= pipe_data;
        end
      end
    end else if (ingress) begin
      skid_valid <= 1'b1;
      skid_data  <= pipe_data;
    end
  end
`else
  assign ce      = !vld[LATENCY-1] || m_ready;
  assign m_valid = vld[LATENCY-1];
  assign m_data  = pipe_data;
`endif

  // Pixels held anywhere between source accept and sink accept.
  always_comb begin
    cnt_nxt = cnt;
    if (src_acc && !snk_acc) begin
      cnt_nxt = cnt + CW'(1);
    end else if (!src_acc && snk_acc) begin
      cnt_nxt = cnt - CW'(1);
    end
  end

  always_comb begin
    state_nxt      = state;
    flush_done_nxt = 1'b0;
    unique case (state)
      IDLE: begin
        if (flush) begin
          state_nxt = FLUSH;
        end else if (src_acc) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (flush) begin
          state_nxt = FLUSH;
        end else if (cnt_nxt == '0) begin
          state_nxt = IDLE;
        end
      end
      FLUSH: begin
        if (cnt == '0) begin
          state_nxt      = IDLE;
          flush_done_nxt = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      flush_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      flush_done <= flush_done_nxt;
    end
  end

endmodule

// File: tb/tb_ycbcr_pipe_ctrl.sv
// Self-checking bench for ycbcr_pipe_ctrl: emulates the ce-driven datapath and scores the stream
// against an in-order pixel queue and an in-flight count.
`timescale 1ns/1ps
module tb_ycbcr_pipe_ctrl;

  localparam int L = 8;
  localparam int N = 24;
`ifdef YCBCR_PIPE_CTRL_SKID_EN
  localparam int EXP_LAT = L + 1;
  localparam int CNT_MAX = L + 2;
  localparam bit SKID    = 1'b1;
`else
  localparam int EXP_LAT = L;
  localparam int CNT_MAX = L;
  localparam bit SKID    = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         s_valid, s_ready, ce;
  logic [N-1:0] s_data, pipe_data;
  logic         m_valid, m_ready;
  logic [N-1:0] m_data;
  logic         flush, flush_done, busy;

  always #5 clk = ~clk;

  ycbcr_pipe_ctrl #(.LATENCY(L), .N(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .ce(ce),
    .pipe_data(pipe_data),
    .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
    .flush(flush), .flush_done(flush_done), .busy(busy)
  );

  int n_cmp = 0, n_err = 0, cyc_n = 0, occ = 0, peak = 0;
  int n_acc = 0, n_snk = 0, first_acc = -1, first_mv = -1, first_snk = -1, last_snk = -1;
  int a0, s0;
  bit got_fd;
  logic [N-1:0] exp_q[$];
  logic [N-1:0] stage [L];
  logic         pv_hold = 1'b0;
  logic [N-1:0] pv_data = '0;
  logic         ce_s, sr_s, fd_s;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: sample mid-cycle, score, then advance the emulated datapath after the edge.
  task automatic cyc();
    logic acc, snk;
    logic [N-1:0] din, exp_d;
    #1;
    ce_s = ce; sr_s = s_ready; fd_s = flush_done;
    acc = s_valid && s_ready;
    snk = m_valid && m_ready;
    din = s_data;
    chk("cnt", 32'(dut.cnt), 32'(occ));
    chk("busy", 32'(busy), 32'(occ != 0));
    chk("cnt_bound", 32'(32'(dut.cnt) <= 32'(CNT_MAX)), 32'd1);
    if (pv_hold) begin
      chk("hold_valid", 32'(m_valid), 32'd1);
      chk("hold_data", 32'(m_data), 32'(pv_data));
    end
    if (snk) begin
      chk("beat_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        exp_d = exp_q.pop_front();
        chk("m_data", 32'(m_data), 32'(exp_d));
      end
      n_snk++;
      if (first_snk < 0) first_snk = cyc_n;
      last_snk = cyc_n;
    end
    if (acc) begin
      exp_q.push_back(din);
      n_acc++;
      if (first_acc < 0) first_acc = cyc_n;
    end
    if (m_valid && first_mv < 0) first_mv = cyc_n;
    occ = occ + (acc ? 1 : 0) - (snk ? 1 : 0);
    if (occ > peak) peak = occ;
    pv_hold = m_valid && !m_ready;
    pv_data = m_data;
    @(posedge clk);
    #1;
    if (ce_s) begin
      for (int k = L - 1; k > 0; k--) stage[k] = stage[k-1];
      stage[0] = din;
    end
    pipe_data = stage[L-1];
    @(negedge clk);
    cyc_n++;
  endtask

  task automatic step(input logic sv, input logic mr, input logic fl);
    s_valid = sv;
    m_ready = mr;
    flush   = fl;
    s_data  = N'($urandom);
    cyc();
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && occ != 0; i++) step(1'b0, 1'b1, 1'b0);
    chk("drain", 32'(occ), 32'd0);
  endtask

  task automatic mark();
    a0 = n_acc; s0 = n_snk;
    first_acc = -1; first_mv = -1; first_snk = -1; last_snk = -1;
  endtask

  initial begin
    s_valid = 1'b0; m_ready = 1'b0; flush = 1'b0; s_data = '0;
    for (int k = 0; k < L; k++) stage[k] = '0;
    pipe_data = '0;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ce", 32'(ce), 32'd1);
    chk("rst_s_ready", 32'(s_ready), 32'd1);
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_flush_done", 32'(flush_done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    if (SKID) chk("rst_m_data", 32'(m_data), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 20 back-to-back pixels, sink always ready
    mark();
    for (int i = 0; i < 100 && n_acc - a0 < 20; i++) step(1'b1, 1'b1, 1'b0);
    drain();
    chk("t1_latency", 32'(first_mv - first_acc), 32'(EXP_LAT));
    chk("t1_beats", 32'(n_snk - s0), 32'd20);
    chk("t1_throughput", 32'(last_snk - first_snk), 32'd19);
    chk("t1_busy_end", 32'(busy), 32'd0);

    // sink stalls for 5 cycles after beat 3
    mark();
    for (int i = 0; i < 100 && n_snk - s0 < 3; i++) step(n_acc - a0 < 12, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(n_acc - a0 < 12, 1'b0, 1'b0);
      if (!SKID || i >= 2) begin
        chk("t2_stall_ce", 32'(ce_s), 32'd0);
        chk("t2_stall_s_ready", 32'(sr_s), 32'd0);
      end
    end
    for (int i = 0; i < 100 && n_acc - a0 < 12; i++) step(1'b1, 1'b1, 1'b0);
    drain();
    chk("t2_beats", 32'(n_snk - s0), 32'd12);

    // three sparse pixels into a stalled sink
    mark();
    peak = occ;
    for (int i = 0; i < 7; i++) step(i % 3 == 0, 1'b0, 1'b0);
    for (int i = 0; i < 15; i++) step(1'b0, 1'b0, 1'b0);
    chk("t3_peak", 32'(peak), 32'd3);
    chk("t3_ce_frozen", 32'(ce_s), 32'd0);
    drain();
    chk("t3_beats", 32'(n_snk - s0), 32'd3);

    // flush with 5 in flight; the 5th pixel arrives alongside the flush request
    mark();
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    chk("t4_accept_with_flush", 32'(sr_s), 32'd1);
    got_fd = 1'b0;
    for (int i = 0; i < 100 && !got_fd; i++) begin
      step(1'b1, 1'b1, 1'b0);
      if (fd_s) got_fd = 1'b1;
      else chk("t4_s_ready_in_flush", 32'(sr_s), 32'd0);
    end
    chk("t4_flush_done_seen", 32'(got_fd), 32'd1);
    chk("t4_beats", 32'(n_snk - s0), 32'd5);
    chk("t4_idle_s_ready", 32'(sr_s), 32'd1);
    step(1'b0, 1'b1, 1'b0);
    chk("t4_single_pulse", 32'(fd_s), 32'd0);
    drain();

    // flush from an empty pipe, second request while flushing is ignored
    step(1'b0, 1'b1, 1'b1);
    chk("t5_fd_c0", 32'(fd_s), 32'd0);
    step(1'b0, 1'b1, 1'b1);
    chk("t5_fd_c1", 32'(fd_s), 32'd0);
    chk("t5_flush_s_ready", 32'(sr_s), 32'd0);
    step(1'b0, 1'b1, 1'b0);
    chk("t5_fd_c2", 32'(fd_s), 32'd1);
    chk("t5_idle_s_ready", 32'(sr_s), 32'd1);
    step(1'b0, 1'b1, 1'b0);
    chk("t5_fd_c3", 32'(fd_s), 32'd0);
    step(1'b0, 1'b1, 1'b0);
    chk("t5_fd_c4", 32'(fd_s), 32'd0);

    // reset in the middle of a stream
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("t6_m_valid", 32'(m_valid), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_cnt", 32'(dut.cnt), 32'd0);
    chk("t6_ce", 32'(ce), 32'd1);
    s_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    occ = 0;
    pv_hold = 1'b0;
    mark();
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0);
    drain();
    chk("t6_latency", 32'(first_mv - first_acc), 32'(EXP_LAT));
    chk("t6_beats", 32'(n_snk - s0), 32'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
